// File: rtl/fp_alu_cluster_if.sv
// Controller-facing bundle for fp_alu_cluster: operand, select and opcode
// inputs plus the combinational and registered results.
interface fp_alu_cluster_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
);
    logic [EXP_W-1:0] small_a;
    logic [EXP_W-1:0] small_b;
    logic             small_mux_a;
    logic             small_mux_b;
    logic             small_load_reg;
    logic [3:0]       small_alu_op;
    logic [EXP_W-1:0] small_result;

    logic [MAN_W-1:0] big_a;
    logic [MAN_W-1:0] big_b;
    logic             big_load_reg_a;
    logic             big_load_reg_b;
    logic             big_mux_a;
    logic             big_mux_b;
    logic             big_mux_c;
    logic [3:0]       big_alu_op;
    logic             sum_or_mult;
    logic [MAN_W:0]   big_result;
    logic             end_multiplication;

    logic             incdec_en;
    logic [EXP_W-1:0] incdec_in;
    logic [3:0]       incdec_op;
    logic [EXP_W-1:0] incdec_result;

    // FP controller side
    modport master (
        output small_a, small_b, small_mux_a, small_mux_b, small_load_reg, small_alu_op,
        output big_a, big_b, big_load_reg_a, big_load_reg_b, big_mux_a, big_mux_b,
        output big_mux_c, big_alu_op, sum_or_mult,
        output incdec_en, incdec_in, incdec_op,
        input  small_result, big_result, end_multiplication, incdec_result
    );

    // Arithmetic cluster side
    modport slave (
        input  small_a, small_b, small_mux_a, small_mux_b, small_load_reg, small_alu_op,
        input  big_a, big_b, big_load_reg_a, big_load_reg_b, big_mux_a, big_mux_b,
        input  big_mux_c, big_alu_op, sum_or_mult,
        input  incdec_en, incdec_in, incdec_op,
        output small_result, big_result, end_multiplication, incdec_result
    );
endinterface

// File: rtl/fp_alu_cluster.sv
// fp_alu_cluster: exponent ALU with accumulator, mantissa ALU with an optional
// sequential shift-add multiplier, and a registered exponent inc/dec unit.
// Define FP_ALU_MULT_EN to compile in the multiplier; without it sum_or_mult is
// ignored, end_multiplication is 0 and the product path reads as 0.
module fp_alu_cluster #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input logic         clk,
    input logic         rst_n,
    fp_alu_cluster_if.slave bus
);
    localparam logic [EXP_W-1:0] BIAS = EXP_W'(127);

    // ---------------- small (exponent) ALU ----------------
    logic [EXP_W-1:0] smallAcc;
    logic [EXP_W-1:0] smallOpA;
    logic [EXP_W-1:0] smallOpB;
    logic [EXP_W-1:0] smallRes;

    // Operand selection and opcode decode for the exponent ALU
    always_comb begin
        smallOpA = bus.small_mux_a ? smallAcc : bus.small_a;
        smallOpB = bus.small_mux_b ? BIAS : bus.small_b;
        case (bus.small_alu_op)
            4'b0000: smallRes = smallOpA + smallOpB;
            4'b0001: smallRes = smallOpA - smallOpB;
            4'b0010: smallRes = smallOpB - smallOpA;
            default: smallRes = smallOpA;
        endcase
    end

    assign bus.small_result = smallRes;

    // Exponent accumulator, loaded from the ALU result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smallAcc <= '0;
        end else if (bus.small_load_reg) begin
            smallAcc <= smallRes;
        end
    end

    // ---------------- big (mantissa) ALU ----------------
    logic [MAN_W-1:0] regA;
    logic [MAN_W-1:0] regB;
    logic [MAN_W:0]   bigOpA;
    logic [MAN_W:0]   bigOpB;
    logic [MAN_W:0]   bigSum;
    logic [MAN_W:0]   productSlice;

    // Mantissa operand registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regA <= '0;
            regB <= '0;
        end else begin
            if (bus.big_load_reg_a) regA <= bus.big_a;
            if (bus.big_load_reg_b) regB <= bus.big_b;
        end
    end

    // Operand selection and opcode decode for the mantissa adder
    always_comb begin
        bigOpA = {1'b0, (bus.big_mux_a ? regA : bus.big_a)};
        bigOpB = {1'b0, (bus.big_mux_b ? regB : bus.big_b)};
        case (bus.big_alu_op)
            4'b0000: bigSum = bigOpA + bigOpB;
            4'b0001: bigSum = bigOpA - bigOpB;
            4'b0010: bigSum = bigOpB - bigOpA;
            default: bigSum = bigOpA;
        endcase
    end

    assign bus.big_result = bus.big_mux_c ? productSlice : bigSum;

`ifdef FP_ALU_MULT_EN
    // ---------------- sequential shift-add multiplier ----------------
    localparam int CNT_W = $clog2(MAN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAN_W - 1);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mulState_t;

    mulState_t        mulState;
    mulState_t        mulNext;
    logic             sumOrMultPrev;
    logic             sumRise;
    logic             startMult;
    logic             stepMult;
    logic [CNT_W-1:0] iterCnt;
    logic [2*MAN_W-1:0] multiplicand;
    logic [MAN_W-1:0]   multiplier;
    logic [2*MAN_W-1:0] product;

    assign sumRise = bus.sum_or_mult & ~sumOrMultPrev;

    // Multiplier state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mulState <= MUL_IDLE;
        end else begin
            mulState <= mulNext;
        end
    end

    // Next-state and datapath strobes; a low sum_or_mult leaves BUSY or DONE
    always_comb begin
        mulNext   = mulState;
        startMult = 1'b0;
        stepMult  = 1'b0;
        case (mulState)
            MUL_IDLE: begin
                if (sumRise) begin
                    startMult = 1'b1;
                    mulNext   = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (!bus.sum_or_mult) begin
                    mulNext = MUL_IDLE;
                end else begin
                    stepMult = 1'b1;
                    if (iterCnt == LAST_ITER) mulNext = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (!bus.sum_or_mult) mulNext = MUL_IDLE;
            end
            default: mulNext = MUL_IDLE;
        endcase
    end

    // Multiplier datapath; start samples regA/regB before any same-edge load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sumOrMultPrev <= 1'b0;
            iterCnt       <= '0;
            multiplicand  <= '0;
            multiplier    <= '0;
            product       <= '0;
        end else begin
            sumOrMultPrev <= bus.sum_or_mult;
            if (startMult) begin
                multiplicand <= {{MAN_W{1'b0}}, regA};
                multiplier   <= regB;
                product      <= '0;
                iterCnt      <= '0;
            end else if (stepMult) begin
                if (multiplier[0]) product <= product + multiplicand;
                multiplicand <= multiplicand << 1;
                multiplier   <= multiplier >> 1;
                iterCnt      <= iterCnt + 1'b1;
            end
        end
    end

    assign productSlice           = product[2*MAN_W-1:MAN_W-1];
    assign bus.end_multiplication = (mulState == MUL_DONE);
`else
    logic unusedSumOrMult;

    assign unusedSumOrMult        = bus.sum_or_mult;
    assign productSlice           = '0;
    assign bus.end_multiplication = 1'b0;
`endif

    // ---------------- exponent inc/dec unit ----------------
    logic [EXP_W-1:0] incdecReg;

    // Registered load / increment / decrement, wrapping modulo 2^EXP_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            incdecReg <= '0;
        end else if (bus.incdec_en) begin
            case (bus.incdec_op)
                4'b0000: incdecReg <= bus.incdec_in;
                4'b0001: incdecReg <= bus.incdec_in + 1'b1;
                4'b0010: incdecReg <= bus.incdec_in - 1'b1;
                default: incdecReg <= incdecReg;
            endcase
        end
    end

    assign bus.incdec_result = incdecReg;

endmodule

// File: tb/tb_fp_alu_cluster.sv
// Directed testbench for fp_alu_cluster (EXP_W=8, MAN_W=24). Multiply checks
// follow FP_ALU_MULT_EN so the bench matches whichever build it is compiled with.
module tb_fp_alu_cluster;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_alu_cluster_if #(.EXP_W(8), .MAN_W(24)) bus ();

    fp_alu_cluster #(.EXP_W(8), .MAN_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        bus.small_a = '0; bus.small_b = '0; bus.small_mux_a = 0; bus.small_mux_b = 0;
        bus.small_load_reg = 0; bus.small_alu_op = 4'd0;
        bus.big_a = '0; bus.big_b = '0; bus.big_load_reg_a = 0; bus.big_load_reg_b = 0;
        bus.big_mux_a = 0; bus.big_mux_b = 0; bus.big_mux_c = 0; bus.big_alu_op = 4'd0;
        bus.sum_or_mult = 0; bus.incdec_en = 0; bus.incdec_in = '0; bus.incdec_op = 4'd0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();

        // Reset state
        chk("rst_incdec", 32'(bus.incdec_result), 32'h0);
        chk("rst_endmul", 32'(bus.end_multiplication), 32'h0);
        bus.small_mux_a = 1; bus.small_alu_op = 4'd3; #1;
        chk("rst_acc", 32'(bus.small_result), 32'h0);
        bus.big_mux_a = 1; bus.big_alu_op = 4'd3; #1;
        chk("rst_regA", 32'(bus.big_result), 32'h0);
        bus.big_mux_c = 1; #1;
        chk("rst_product", 32'(bus.big_result), 32'h0);
        bus.big_mux_a = 0; bus.big_mux_c = 0;

        // Small ALU bias path
        bus.small_mux_a = 0; bus.small_a = 8'h85; bus.small_b = 8'h80;
        bus.small_alu_op = 4'd0; bus.small_load_reg = 1; #1;
        chk("small_add_wrap", 32'(bus.small_result), 32'h05);
        tick();
        bus.small_load_reg = 0; bus.small_mux_a = 1; bus.small_mux_b = 1;
        bus.small_alu_op = 4'd1; #1;
        chk("small_bias_sub", 32'(bus.small_result), 32'h86);
        bus.small_mux_a = 0; bus.small_mux_b = 0;
        bus.small_a = 8'h10; bus.small_b = 8'h30; bus.small_alu_op = 4'd2; #1;
        chk("small_b_minus_a", 32'(bus.small_result), 32'h20);
        bus.small_alu_op = 4'd7; #1;
        chk("small_pass_a", 32'(bus.small_result), 32'h10);

        // Big ALU
        bus.big_a = 24'hC00000; bus.big_b = 24'h800000; bus.big_alu_op = 4'd0; #1;
        chk("big_add_carry", 32'(bus.big_result), 32'h1400000);
        bus.big_a = 24'h800000; bus.big_b = 24'hC00000; bus.big_alu_op = 4'd2; #1;
        chk("big_b_minus_a", 32'(bus.big_result), 32'h0400000);
        bus.big_alu_op = 4'd1; #1;
        chk("big_a_minus_b_wrap", 32'(bus.big_result), 32'h1C00000);
        bus.big_alu_op = 4'd9; #1;
        chk("big_pass_a", 32'(bus.big_result), 32'h0800000);

        // Load regA/regB with 1.0 and read them back through the muxes
        bus.big_a = 24'h800000; bus.big_b = 24'h800000;
        bus.big_load_reg_a = 1; bus.big_load_reg_b = 1;
        tick();
        bus.big_load_reg_a = 0; bus.big_load_reg_b = 0;
        bus.big_a = 24'h000001; bus.big_b = 24'h000002;
        bus.big_mux_a = 1; bus.big_mux_b = 1; bus.big_alu_op = 4'd0; #1;
        chk("big_reg_add", 32'(bus.big_result), 32'h1000000);
        bus.big_mux_a = 0; bus.big_mux_b = 0;

`ifdef FP_ALU_MULT_EN
        // 1.0 x 1.0
        bus.sum_or_mult = 1;
        tick();
        chk("mul1_not_done_at_start", 32'(bus.end_multiplication), 32'h0);
        k = 0;
        while (bus.end_multiplication !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("mul1_latency", 32'(k), 32'd24);
        bus.big_mux_c = 1; #1;
        chk("mul1_product", 32'(bus.big_result), 32'h0800000);
        bus.sum_or_mult = 0; #1;
        chk("mul1_end_held", 32'(bus.end_multiplication), 32'h1);
        tick();
        chk("mul1_end_clear", 32'(bus.end_multiplication), 32'h0);

        // 1.5 x 1.5, loaded one cycle before the start
        bus.big_a = 24'hC00000; bus.big_b = 24'hC00000;
        bus.big_load_reg_a = 1; bus.big_load_reg_b = 1;
        tick();
        bus.big_load_reg_a = 0; bus.big_load_reg_b = 0;
        bus.sum_or_mult = 1;
        tick();
        k = 0;
        while (bus.end_multiplication !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("mul2_latency", 32'(k), 32'd24);
        chk("mul2_product", 32'(bus.big_result), 32'h1200000);
        tick(); tick(); tick();
        chk("mul2_end_stays", 32'(bus.end_multiplication), 32'h1);
        chk("mul2_product_stable", 32'(bus.big_result), 32'h1200000);
        bus.sum_or_mult = 0;
        tick();

        // Start-cycle load is ignored: multiplier uses 1.0 x 0xC00003
        bus.big_a = 24'h800000; bus.big_b = 24'hC00003;
        bus.big_load_reg_a = 1; bus.big_load_reg_b = 1;
        tick();
        bus.big_a = 24'hFFFFFF; bus.big_b = 24'hFFFFFF;
        bus.sum_or_mult = 1;
        tick();
        bus.big_load_reg_a = 0; bus.big_load_reg_b = 0;
        // Five iterations consume bits 0..4 (bits 0,1 set): product = 3 * 2^23
        tick(); tick(); tick(); tick(); tick();
        bus.sum_or_mult = 0;
        for (int i = 0; i < 30; i++) tick();
        chk("abort_no_end", 32'(bus.end_multiplication), 32'h0);
        chk("abort_product_kept", 32'(bus.big_result), 32'h3);

        // Reset during a multiply
        bus.sum_or_mult = 1;
        tick(); tick(); tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.sum_or_mult = 0;
        #1;
        chk("rst_mid_end", 32'(bus.end_multiplication), 32'h0);
        chk("rst_mid_product", 32'(bus.big_result), 32'h0);
`else
        // Multiplier compiled out
        bus.sum_or_mult = 1;
        for (int i = 0; i < 30; i++) tick();
        chk("nomul_end", 32'(bus.end_multiplication), 32'h0);
        bus.big_mux_c = 1; #1;
        chk("nomul_product", 32'(bus.big_result), 32'h0);
        bus.sum_or_mult = 0;
`endif
        bus.big_mux_c = 0;

        // Inc/dec unit
        bus.incdec_in = 8'hFF; bus.incdec_op = 4'd1; bus.incdec_en = 1;
        tick();
        chk("inc_wrap", 32'(bus.incdec_result), 32'h00);
        bus.incdec_in = 8'h00; bus.incdec_op = 4'd2;
        tick();
        chk("dec_wrap", 32'(bus.incdec_result), 32'hFF);
        bus.incdec_en = 0; bus.incdec_in = 8'h33; bus.incdec_op = 4'd0;
        tick();
        chk("incdec_hold_en0", 32'(bus.incdec_result), 32'hFF);
        bus.incdec_en = 1; bus.incdec_in = 8'h5A; bus.incdec_op = 4'd0;
        tick();
        chk("incdec_load", 32'(bus.incdec_result), 32'h5A);
        bus.incdec_in = 8'h11; bus.incdec_op = 4'd5;
        tick();
        chk("incdec_hold_op", 32'(bus.incdec_result), 32'h5A);

        // Final reset clears accumulator, regA and inc/dec
        bus.small_a = 8'h44; bus.small_b = 8'h01; bus.small_alu_op = 4'd0;
        bus.small_load_reg = 1;
        bus.big_a = 24'h123456; bus.big_load_reg_a = 1;
        tick();
        bus.small_load_reg = 0; bus.big_load_reg_a = 0; bus.incdec_en = 0;
        bus.small_mux_a = 1; bus.small_alu_op = 4'd3; #1;
        chk("acc_loaded", 32'(bus.small_result), 32'h45);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("final_rst_acc", 32'(bus.small_result), 32'h0);
        chk("final_rst_incdec", 32'(bus.incdec_result), 32'h0);
        bus.big_mux_a = 1; bus.big_alu_op = 4'd3; #1;
        chk("final_rst_regA", 32'(bus.big_result), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
